// File: rtl/parity_frame_unit.sv
// Streaming frame parity generator: folds up to FRAME_LEN words of WIDTH bits into one parity bit.
// Optional frame checker (chk_parity/out_error) is built when PARITY_CHECK_EN is defined.
module parity_frame_unit #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int ODD       = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_last,
`ifdef PARITY_CHECK_EN
  input  logic                             chk_parity,
  output logic                             out_error,
`endif
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_parity,
  output logic [$clog2(FRAME_LEN+1)-1:0]   out_count,
  output logic                             busy
);

  localparam int CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t          state_q, state_d;
  logic            acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            par_q, par_d;
  logic [CW-1:0]   count_q, count_d;

  logic            odd_bit;
  logic            accept;
  logic            word_par;
  logic            starting;
  logic            new_acc;
  logic [CW-1:0]   new_cnt;
  logic            frame_end;

  assign odd_bit  = (ODD != 0);
  assign in_ready = (state_q != DONE) | out_ready;
  assign accept   = in_valid & in_ready;
  assign word_par = ^in_data;
  // Any accepted word outside ACCUM opens a fresh frame, including one taken while the result retires.
  assign starting = (state_q != ACCUM);
  assign new_acc  = starting ? word_par : (acc_q ^ word_par);
  assign new_cnt  = starting ? CW'(1) : (cnt_q + CW'(1));
  assign frame_end = in_last | (new_cnt == CW'(FRAME_LEN));

`ifdef PARITY_CHECK_EN
  logic err_q, err_d;
  assign out_error = err_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    count_d = count_q;
`ifdef PARITY_CHECK_EN
    err_d   = err_q;
`endif
    if (accept) begin
      acc_d = new_acc;
      cnt_d = new_cnt;
      if (frame_end) begin
        state_d = DONE;
        par_d   = new_acc ^ odd_bit;
        count_d = new_cnt;
`ifdef PARITY_CHECK_EN
        err_d   = chk_parity ^ (new_acc ^ odd_bit);
`endif
      end else begin
        state_d = ACCUM;
      end
    end else if ((state_q == DONE) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      count_q <= '0;
`ifdef PARITY_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      count_q <= count_d;
`ifdef PARITY_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == ACCUM);
  assign out_parity = par_q;
  assign out_count  = count_q;

endmodule

// File: tb/tb_parity_frame_unit.sv
// Bench for parity_frame_unit: three configurations share one stimulus stream, each checked
// every cycle against a ones-counting frame model, plus directed literal expectations.
module tb_parity_frame_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       chk = 1'b0;
  bit         cmp_en = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Instance 0: FRAME_LEN=4 odd; instance 1: FRAME_LEN=4 even; instance 2: FRAME_LEN=1 odd.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int FL = (gi == 2) ? 1 : 4;
    localparam int OD = (gi == 1) ? 0 : 1;
    localparam int CW = $clog2(FL + 1);

    logic          w_ready, w_valid, w_par, w_busy;
    logic [CW-1:0] w_cnt;
    logic          w_err;

    parity_frame_unit #(.WIDTH(8), .FRAME_LEN(FL), .ODD(OD)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (w_ready),
      .in_data    (in_data),
      .in_last    (in_last),
`ifdef PARITY_CHECK_EN
      .chk_parity (chk),
      .out_error  (w_err),
`endif
      .out_valid  (w_valid),
      .out_ready  (out_ready),
      .out_parity (w_par),
      .out_count  (w_cnt),
      .busy       (w_busy)
    );

`ifndef PARITY_CHECK_EN
    assign w_err = 1'b0;
`endif

    // Model: a frame is a running ones count plus word count; a finished frame is a held result.
    bit m_res = 1'b0;
    int m_par = 0, m_cnt = 0, m_err = 0, m_ones = 0, m_words = 0;

    always @(posedge clk) begin
      if (!reset_n) begin
        m_res <= 1'b0; m_par <= 0; m_cnt <= 0; m_err <= 0; m_ones <= 0; m_words <= 0;
      end else begin
        if (m_res && out_ready) m_res <= 1'b0;
        if (in_valid && (!m_res || out_ready)) begin
          if (in_last || (m_words + 1 == FL)) begin
            m_res   <= 1'b1;
            m_par   <= ((m_ones + $countones(in_data)) % 2) ^ OD;
            m_err   <= int'(chk) ^ (((m_ones + $countones(in_data)) % 2) ^ OD);
            m_cnt   <= m_words + 1;
            m_words <= 0;
            m_ones  <= 0;
          end else begin
            m_words <= m_words + 1;
            m_ones  <= m_ones + $countones(in_data);
          end
        end
      end
    end

    always @(negedge clk) begin
      if (cmp_en) begin
        check($sformatf("in_ready[%0d]", gi), int'(w_ready), int'(!m_res || out_ready));
        check($sformatf("out_valid[%0d]", gi), int'(w_valid), int'(m_res));
        check($sformatf("busy[%0d]", gi), int'(w_busy), int'(m_words > 0));
        check($sformatf("out_parity[%0d]", gi), int'(w_par), m_par);
        check($sformatf("out_count[%0d]", gi), int'(w_cnt), m_cnt);
`ifdef PARITY_CHECK_EN
        if (m_res) check($sformatf("out_error[%0d]", gi), int'(w_err), m_err);
`endif
        if (gi == 0 && w_valid && out_ready)
          $display("frame retired: parity=%0d count=%0d", w_par, w_cnt);
      end
    end
  end

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r, input bit c);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    chk       = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    #1;
    check("reset valid", int'(g_dut[0].w_valid), 0);
    check("reset busy", int'(g_dut[0].w_busy), 0);
    check("reset ready", int'(g_dut[0].w_ready), 1);
    check("reset count", int'(g_dut[0].w_cnt), 0);

    // Full odd frame 01,03,00,00
    step(1, 8'h01, 0, 1, 0);
    step(1, 8'h03, 0, 1, 0);
    step(1, 8'h00, 0, 1, 0);
    step(1, 8'h00, 0, 1, 0);
    #1;
    check("full valid", int'(g_dut[0].w_valid), 1);
    check("full parity odd", int'(g_dut[0].w_par), 0);
    check("full count", int'(g_dut[0].w_cnt), 4);
    check("full parity even", int'(g_dut[1].w_par), 1);
    check("fl1 zero word parity", int'(g_dut[2].w_par), 1);

    // Early end FF,01 with in_last
    step(1, 8'hFF, 0, 1, 0);
    step(1, 8'h01, 1, 1, 0);
    #1;
    check("early valid even", int'(g_dut[1].w_valid), 1);
    check("early parity even", int'(g_dut[1].w_par), 1);
    check("early count even", int'(g_dut[1].w_cnt), 2);
    check("early parity odd", int'(g_dut[0].w_par), 0);

    // Back-pressure: result held, no word taken
    for (int i = 0; i < 5; i++) begin
      step(1, 8'h55, 0, 0, 0);
      #1;
      check("bp ready", int'(g_dut[0].w_ready), 0);
      check("bp valid", int'(g_dut[0].w_valid), 1);
      check("bp count", int'(g_dut[0].w_cnt), 2);
    end
    step(1, 8'h55, 0, 1, 0);
    #1;
    check("bp release busy", int'(g_dut[0].w_busy), 1);
    check("bp release valid", int'(g_dut[0].w_valid), 0);
    step(1, 8'h01, 1, 1, 0);
    #1;
    check("bp frame count", int'(g_dut[0].w_cnt), 2);
    check("bp frame parity", int'(g_dut[0].w_par), 0);

    // Back-to-back single-word frames
    step(1, 8'h01, 0, 1, 0);
    #1;
    check("b2b0 valid", int'(g_dut[2].w_valid), 1);
    check("b2b0 parity", int'(g_dut[2].w_par), 0);
    step(1, 8'h02, 0, 1, 0);
    #1;
    check("b2b1 valid", int'(g_dut[2].w_valid), 1);
    check("b2b1 parity", int'(g_dut[2].w_par), 0);
    step(1, 8'h03, 0, 1, 0);
    #1;
    check("b2b2 valid", int'(g_dut[2].w_valid), 1);
    check("b2b2 parity", int'(g_dut[2].w_par), 1);
    step(1, 8'h00, 1, 1, 0);
    step(0, 8'h00, 0, 1, 0);

    // Reset mid-frame, word during reset is dropped
    step(1, 8'h0F, 0, 1, 0);
    step(1, 8'h0F, 0, 1, 0);
    #1;
    check("mid busy", int'(g_dut[0].w_busy), 1);
    reset_n = 1'b0;
    step(1, 8'hAA, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    check("rst valid", int'(g_dut[0].w_valid), 0);
    check("rst busy", int'(g_dut[0].w_busy), 0);
    check("rst ready", int'(g_dut[0].w_ready), 1);
    for (int i = 0; i < 4; i++) step(1, 8'h00, 0, 1, 0);
    #1;
    check("post rst parity", int'(g_dut[0].w_par), 1);
    check("post rst count", int'(g_dut[0].w_cnt), 4);

`ifdef PARITY_CHECK_EN
    step(1, 8'h07, 1, 1, 1);
    #1;
    check("chk1 parity", int'(g_dut[0].w_par), 0);
    check("chk1 error", int'(g_dut[0].w_err), 1);
    step(1, 8'h07, 1, 1, 0);
    #1;
    check("chk0 error", int'(g_dut[0].w_err), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 7, 1'($urandom));
    end
    step(0, 8'h00, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
